// File: rtl/flash_reader.sv
// flash_reader: EPCS serial-flash read engine. Issues READ BYTES (0x03) with a
// 24-bit start address and streams rd_len bytes out over a valid/ready port.
// The serial clock is paused low between bytes while the consumer stalls,
// so the flash keeps its place and no data is lost.
module flash_reader #(
  parameter int CLK_DIV = 2,  // clock cycles per DCLK half-period
  parameter int CS_HIGH = 4,  // min cycles FLASH_NCE stays high after a transfer
  parameter int BIT_REV = 0   // 1 = bit-reverse each received byte
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_req,
  input  logic [23:0] rd_addr,
  input  logic [8:0]  rd_len,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_done,
  output logic        DCLK,
  output logic        DATAOUT,
  input  logic        DATAIN,
  output logic        FLASH_NCE
);

  typedef enum logic [2:0] {
    IDLE, SEL, CMD, ADDR, DATA, HOLD, DESEL, DONE
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] CS_LAST  = 16'(CS_HIGH - 1);
  localparam logic [7:0]  READ_CMD = 8'h03;

  state_t      state;
  logic [15:0] timer;      // half-period / setup / deselect timer
  logic [4:0]  bit_cnt;    // bits completed in the current field
  logic [31:0] tx_sr;      // command + address, shifted out MSB first
  logic [7:0]  rx_sr;      // incoming data byte, MSB first
  logic [8:0]  remaining;  // bytes still to deliver, including the one in flight
  logic [7:0]  rx_byte;    // rx_sr in consumer bit order

  // Present the received byte either as-is or bit-reversed
  generate
    if (BIT_REV != 0) begin : g_rev
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign rx_byte[gi] = rx_sr[7-gi];
      end
    end else begin : g_fwd
      assign rx_byte = rx_sr;
    end
  endgenerate

  // Read sequencer: chip select, bit-serial engine and consumer handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      DCLK      <= 1'b0;
      DATAOUT   <= 1'b0;
      FLASH_NCE <= 1'b1;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            busy <= 1'b1;
            if (rd_len == 9'd0) begin
              // Empty request completes without touching the flash
              rd_done <= 1'b1;
              state   <= DONE;
            end else begin
              tx_sr     <= {READ_CMD, rd_addr};
              remaining <= rd_len;
              timer     <= '0;
              FLASH_NCE <= 1'b0;
              state     <= SEL;
            end
          end
        end

        SEL: begin
          // Chip-select setup time with DCLK low, then present the first command bit
          if (timer == DIV_LAST) begin
            timer   <= '0;
            bit_cnt <= '0;
            DATAOUT <= tx_sr[31];
            tx_sr   <= {tx_sr[30:0], 1'b0};
            state   <= CMD;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        CMD, ADDR, DATA: begin
          if (timer != DIV_LAST) begin
            timer <= timer + 16'd1;
          end else begin
            timer <= '0;
            if (!DCLK) begin
              // Rising DCLK: flash samples DATAOUT, we sample DATAIN
              DCLK <= 1'b1;
              if (state == DATA) begin
                rx_sr <= {rx_sr[6:0], DATAIN};
              end
            end else begin
              // Falling DCLK: the only place DATAOUT is allowed to change
              DCLK    <= 1'b0;
              bit_cnt <= bit_cnt + 5'd1;
              if (state == CMD) begin
                DATAOUT <= tx_sr[31];
                tx_sr   <= {tx_sr[30:0], 1'b0};
                if (bit_cnt == 5'd7) begin
                  bit_cnt <= '0;
                  state   <= ADDR;
                end
              end else if (state == ADDR) begin
                if (bit_cnt == 5'd23) begin
                  bit_cnt <= '0;
                  DATAOUT <= 1'b0;
                  state   <= DATA;
                end else begin
                  DATAOUT <= tx_sr[31];
                  tx_sr   <= {tx_sr[30:0], 1'b0};
                end
              end else if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                rd_data  <= rx_byte;
                rd_valid <= 1'b1;
                state    <= HOLD;
              end
            end
          end
        end

        HOLD: begin
          // DCLK parked low; the flash holds its position until the byte is taken
          if (rd_valid && rd_ready) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - 9'd1;
            timer     <= '0;
            if (remaining == 9'd1) begin
              FLASH_NCE <= 1'b1;
              state     <= DESEL;
            end else begin
              state <= DATA;
            end
          end
        end

        DESEL: begin
          // Enforce the minimum chip-select high time before reporting completion
          if (timer == CS_LAST) begin
            timer   <= '0;
            rd_done <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_reader.sv
// tb_flash_reader: randomized bench for flash_reader with a behavioural EPCS
// flash model. A second instance with BIT_REV=1 runs in lockstep on the same
// flash stream so both byte orders are checked on every transaction.
module tb_flash_reader;

  localparam int CLK_DIV = 2;
  localparam int CS_HIGH = 4;
  localparam int BUDGET  = 20000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [23:0] rd_addr = '0;
  logic [8:0]  rd_len = '0;
  logic        rd_ready = 1'b0;
  logic        DATAIN = 1'b0;

  logic        busy, rd_valid, rd_done, DCLK, DATAOUT, FLASH_NCE;
  logic [7:0]  rd_data;
  logic        busy_r, rd_valid_r, rd_done_r, dclk_r, dout_r, nce_r;
  logic [7:0]  rd_data_r;

  always #5 clock = ~clock;

  flash_reader #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .BIT_REV(0)) dut (
    .clock(clock), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_len(rd_len), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_done(rd_done), .DCLK(DCLK), .DATAOUT(DATAOUT),
    .DATAIN(DATAIN), .FLASH_NCE(FLASH_NCE)
  );

  flash_reader #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .BIT_REV(1)) dut_rev (
    .clock(clock), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_len(rd_len), .busy(busy_r), .rd_data(rd_data_r), .rd_valid(rd_valid_r),
    .rd_ready(rd_ready), .rd_done(rd_done_r), .DCLK(dclk_r), .DATAOUT(dout_r),
    .DATAIN(DATAIN), .FLASH_NCE(nce_r)
  );

  int checks = 0;
  int errors = 0;

  // Flash contents: fixed bytes at 0x040000, hashed pattern elsewhere
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] h;
    case (a)
      24'h040000: return 8'hA5;
      24'h040001: return 8'h5A;
      24'h040002: return 8'h01;
      24'h040003: return 8'h80;
      default: begin
        h = {8'h00, a} * 32'h9E3779B1;
        return h[23:16];
      end
    endcase
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Flash model: capture header on rising DCLK, drive data on falling DCLK
  int          fl_bits = 0;
  int          fl_rises = 0;
  logic [31:0] fl_hdr = '0;

  always @(negedge FLASH_NCE) begin
    fl_bits = 0;
    fl_hdr  = '0;
  end

  always @(posedge DCLK) begin
    if (!FLASH_NCE) begin
      if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], DATAOUT};
      fl_bits++;
      fl_rises++;
    end
  end

  always @(negedge DCLK) begin
    int idx;
    logic [7:0] b;
    if (!FLASH_NCE && fl_bits >= 32) begin
      idx = fl_bits - 32;
      b = flash_byte(fl_hdr[23:0] + 24'(idx / 8));
      DATAIN = b[7 - (idx % 8)];
    end
  end

  // Output monitor, sampled on the falling clock edge
  logic [7:0] got[$];
  logic [7:0] got_r[$];
  int   done_cnt = 0;
  bit   nce_low_seen = 0;
  bit   valid_seen = 0;
  int   cyc_now = 0;
  int   nce_fall_cyc = -1;
  int   rise1 = -1;
  int   rise2 = -1;
  logic dclk_prev = 1'b0;

  always @(negedge clock) begin
    cyc_now++;
    if (rd_valid && rd_ready) got.push_back(rd_data);
    if (rd_valid_r && rd_ready) got_r.push_back(rd_data_r);
    if (rd_done) done_cnt++;
    if (!FLASH_NCE) nce_low_seen = 1;
    if (rd_valid) valid_seen = 1;
    if (!FLASH_NCE && nce_fall_cyc < 0) nce_fall_cyc = cyc_now;
    if (DCLK && !dclk_prev) begin
      if (rise1 < 0) rise1 = cyc_now;
      else if (rise2 < 0) rise2 = cyc_now;
    end
    dclk_prev = DCLK;
  end

  int       stall_cnt;
  int       hold_bad;
  bit       timed_out;
  logic [7:0] held;

  task automatic clear_obs();
    got.delete();
    got_r.delete();
    done_cnt = 0;
    nce_low_seen = 0;
    valid_seen = 0;
    nce_fall_cyc = -1;
    rise1 = -1;
    rise2 = -1;
    fl_rises = 0;
    fl_bits = 0;
    stall_cnt = 0;
    hold_bad = 0;
    timed_out = 0;
  endtask

  // Issue one read and drive rd_ready until rd_done (mode 0 ready, 1 random,
  // 2 stall byte 2 for 20 cycles, 3 random plus extra rd_req while busy)
  task automatic do_read(input logic [23:0] a, input logic [8:0] n, input int mode);
    int cyc;
    int stall_left;
    clear_obs();
    stall_left = 20;
    @(posedge clock); #1;
    rd_addr = a;
    rd_len  = n;
    rd_req  = 1'b1;
    @(posedge clock); #1;
    rd_req = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < BUDGET) begin
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = ($urandom_range(0, 1) == 1);
        2: begin
          if (rd_valid && got.size() == 1 && stall_left > 0) begin
            rd_ready = 1'b0;
            if (stall_cnt == 0) held = rd_data;
            stall_cnt++;
            stall_left--;
            if (!(rd_valid && rd_data == held && !DCLK && !FLASH_NCE)) hold_bad++;
          end else begin
            rd_ready = 1'b1;
          end
        end
        default: begin
          rd_ready = ($urandom_range(0, 1) == 1);
          rd_req   = busy && (rd_done || $urandom_range(0, 3) == 0);
          rd_len   = 9'($urandom_range(1, 9));
          rd_addr  = 24'($urandom);
        end
      endcase
      @(posedge clock); #1;
      cyc++;
    end
    rd_req    = 1'b0;
    rd_ready  = 1'b0;
    timed_out = (done_cnt == 0);
    repeat (3) @(posedge clock);
    #1;
    $display("read addr=%06h len=%0d mode=%0d bytes=%0d done=%0d cycles=%0d",
             a, n, mode, got.size(), done_cnt, cyc);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rd_done); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rd_data); end
    checks++; if (DCLK !== 1'b0) begin errors++; $display("FAIL reset_dclk: got %b want 0", DCLK); end
    checks++; if (DATAOUT !== 1'b0) begin errors++; $display("FAIL reset_dataout: got %b want 0", DATAOUT); end
    checks++; if (FLASH_NCE !== 1'b1) begin errors++; $display("FAIL reset_nce: got %b want 1", FLASH_NCE); end
    @(negedge clock) reset = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h5A, 8'h01, 8'h80};
    do_read(24'h040000, 9'd4, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got no rd_done want rd_done"); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL basic_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_b[i]); end
    end
    for (int i = 0; i < 4 && i < got_r.size(); i++) begin
      checks++;
      if (got_r[i] !== rev8(exp_b[i])) begin errors++; $display("FAIL bitrev_byte%0d: got %h want %h", i, got_r[i], rev8(exp_b[i])); end
    end
    checks++; if (got_r.size() != 4) begin errors++; $display("FAIL bitrev_count: got %0d want 4", got_r.size()); end
    checks++; if (fl_hdr !== 32'h03040000) begin errors++; $display("FAIL basic_header: got %h want 03040000", fl_hdr); end
    checks++; if (fl_rises != 64) begin errors++; $display("FAIL basic_rises: got %0d want 64", fl_rises); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    checks++; if (FLASH_NCE !== 1'b1) begin errors++; $display("FAIL basic_nce_after: got %b want 1", FLASH_NCE); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_dclk_timing();
    do_read(24'($urandom), 9'd1, 0);
    checks++;
    if (rise1 - nce_fall_cyc != 2 * CLK_DIV) begin
      errors++; $display("FAIL first_rise: got %0d want %0d", rise1 - nce_fall_cyc, 2 * CLK_DIV);
    end
    checks++;
    if (rise2 - rise1 != 2 * CLK_DIV) begin
      errors++; $display("FAIL dclk_period: got %0d want %0d", rise2 - rise1, 2 * CLK_DIV);
    end
  endtask

  task automatic test_stall();
    logic [23:0] a;
    a = 24'($urandom);
    do_read(a, 9'd3, 2);
    checks++; if (stall_cnt != 20) begin errors++; $display("FAIL stall_cycles: got %0d want 20", stall_cnt); end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles want 0", hold_bad); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL stall_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== flash_byte(a + 24'(i))) begin
        errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got[i], flash_byte(a + 24'(i)));
      end
    end
  endtask

  task automatic test_zero_len();
    clear_obs();
    @(posedge clock); #1;
    rd_addr = 24'h123456;
    rd_len  = 9'd0;
    rd_req  = 1'b1;
    @(posedge clock); #1;
    rd_req = 1'b0;
    checks++; if (rd_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", rd_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b want 1", busy); end
    @(posedge clock); #1;
    checks++; if (rd_done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b want 0", rd_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_end: got %b want 0", busy); end
    repeat (10) @(posedge clock);
    #1;
    checks++; if (nce_low_seen) begin errors++; $display("FAIL zero_nce: got low want never low"); end
    checks++; if (valid_seen) begin errors++; $display("FAIL zero_valid: got high want never high"); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", done_cnt); end
    $display("read addr=123456 len=0 done=%0d", done_cnt);
  endtask

  task automatic test_busy_ignore();
    logic [23:0] a;
    logic [8:0]  n;
    a = 24'($urandom);
    n = 9'($urandom_range(2, 6));
    do_read(a, n, 3);
    checks++; if (timed_out) begin errors++; $display("FAIL busy_timeout: got no rd_done want rd_done"); end
    checks++; if (got.size() != int'(n)) begin errors++; $display("FAIL busy_count: got %0d want %0d", got.size(), n); end
    for (int i = 0; i < int'(n) && i < got.size(); i++) begin
      checks++;
      if (got[i] !== flash_byte(a + 24'(i))) begin
        errors++; $display("FAIL busy_byte%0d: got %h want %h", i, got[i], flash_byte(a + 24'(i)));
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
    nce_low_seen = 0;
    repeat (20) @(posedge clock);
    #1;
    checks++; if (nce_low_seen) begin errors++; $display("FAIL busy_requeue: got new transfer want none"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int w;
    logic [23:0] a;
    clear_obs();
    @(posedge clock); #1;
    rd_addr  = 24'hABCDEF;
    rd_len   = 9'd4;
    rd_req   = 1'b1;
    rd_ready = 1'b1;
    @(posedge clock); #1;
    rd_req = 1'b0;
    w = 0;
    while (fl_bits < 12 && w < 500) begin
      @(posedge clock); #1;
      w++;
    end
    checks++; if (fl_bits < 12) begin errors++; $display("FAIL midreset_reach_addr: got %0d bits want 12", fl_bits); end
    #3 reset = 1'b0;
    #1;
    checks++; if (FLASH_NCE !== 1'b1) begin errors++; $display("FAIL midreset_nce: got %b want 1", FLASH_NCE); end
    checks++; if (DCLK !== 1'b0) begin errors++; $display("FAIL midreset_dclk: got %b want 0", DCLK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_no_done: got %0d want 0", done_cnt); end
    $display("read addr=abcdef len=4 aborted by reset");
    a = 24'($urandom);
    do_read(a, 9'd3, 1);
    checks++; if (fl_hdr !== {8'h03, a}) begin errors++; $display("FAIL midreset_header: got %h want %h", fl_hdr, {8'h03, a}); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL midreset_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== flash_byte(a + 24'(i))) begin
        errors++; $display("FAIL midreset_byte%0d: got %h want %h", i, got[i], flash_byte(a + 24'(i)));
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [8:0]  n;
    int          mode;
    for (int t = 0; t < 8; t++) begin
      a = 24'($urandom);
      n = 9'($urandom_range(1, 12));
      mode = 1;
      if (t == 6) begin a = 24'hFFFFFE; n = 9'd5; end
      if (t == 7) begin n = 9'd256; mode = 0; end
      do_read(a, n, mode);
      checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got no rd_done want rd_done", t); end
      checks++; if (got.size() != int'(n)) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", t, got.size(), n); end
      checks++; if (got_r.size() != int'(n)) begin errors++; $display("FAIL rand%0d_rcount: got %0d want %0d", t, got_r.size(), n); end
      for (int i = 0; i < int'(n) && i < got.size(); i++) begin
        checks++;
        if (got[i] !== flash_byte(a + 24'(i))) begin
          errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", t, i, got[i], flash_byte(a + 24'(i)));
        end
      end
      for (int i = 0; i < int'(n) && i < got_r.size(); i++) begin
        checks++;
        if (got_r[i] !== rev8(flash_byte(a + 24'(i)))) begin
          errors++; $display("FAIL rand%0d_rbyte%0d: got %h want %h", t, i, got_r[i], rev8(flash_byte(a + 24'(i))));
        end
      end
      checks++; if (fl_hdr !== {8'h03, a}) begin errors++; $display("FAIL rand%0d_header: got %h want %h", t, fl_hdr, {8'h03, a}); end
      checks++; if (fl_rises != 32 + 8 * int'(n)) begin errors++; $display("FAIL rand%0d_rises: got %0d want %0d", t, fl_rises, 32 + 8 * int'(n)); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", t, done_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dclk_timing();
    test_stall();
    test_zero_len();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
